ahb_gpio_irq: RTL and testbench
===============================

# ahb_gpio_irq

Parametrised AHB-Lite GPIO peripheral that supersedes the fixed 16-bit GPIO slave.
- Pin count, input synchroniser depth and base-offset decode width are configurable.
- Adds per-pin direction control, atomic set/clear output writes, and a per-pin interrupt unit (edge or level, either polarity) with sticky write-1-to-clear status.
- Sits on the AHB-Lite peripheral bus beside the other slaves; drives the pad ring and one combined interrupt line to the CPU.

## Interface
- GPIO_WIDTH, 16, number of pins, 1..32; register bits above GPIO_WIDTH-1 read 0 and ignore writes
- SYNC_STAGES, 2, input synchroniser flops per pin, 2..4
- ADDR_W, 8, HADDR bits decoded, word offsets in HADDR[ADDR_W-1:2]

Ports:
- HCLK in 1 clock, all logic rising-edge
- HRESETn in 1 asynchronous active-low reset
- HSEL in 1 slave select
- HADDR in 32 address, only [ADDR_W-1:2] decoded
- HTRANS in 2 transfer type, NONSEQ/SEQ = valid
- HWRITE in 1 1=write
- HSIZE in 3 ignored, every access treated as a 32-bit word
- HWDATA in 32 write data, data phase
- HREADY in 1 bus ready
- HREADYOUT out 1 constant 1, zero wait states
- HRESP out 1 constant 0 (OKAY)
- HRDATA out 32 read data, data phase
- GPIOIN in GPIO_WIDTH asynchronous pad inputs
- GPIOOUT out GPIO_WIDTH output data register
- GPIOEN out GPIO_WIDTH output enable, equals DIR
- GPIOINT out GPIO_WIDTH per-pin interrupt, equals STATUS
- GPIOIRQ out 1 OR of GPIOINT

## Operation
Register map, word offsets:
- 0x00 DATA: R/W; writes set GPIOOUT.
- 0x04 DIR: R/W; 1 = output.
- 0x08 DIN: RO; synchronised GPIOIN, independent of DIR.
- 0x0C SET: WO; GPIOOUT |= HWDATA; reads 0.
- 0x10 CLR: WO; GPIOOUT &= ~HWDATA; reads 0.
- 0x14 IE: R/W; interrupt enable.
- 0x18 ITYPE: R/W; 1 = edge, 0 = level.
- 0x1C IPOL: R/W; 1 = rising/high, 0 = falling/low.
- 0x20 STATUS: R; W1C for edge pins.
- All other offsets: read 0, writes ignored, still OKAY.

Bus behaviour:
- A transfer is accepted when HSEL & HREADY & HTRANS[1]. HADDR and HWRITE are registered in the address phase.
- Write: HWDATA is applied on the clock edge that ends the data phase.
- Read: HRDATA is driven combinationally from the registered address during the data phase, and is 0 when no read is active.
- Interrupt source: sync = last synchroniser stage; prev = sync delayed by one cycle.
  - Edge pin: event = IPOL ? (sync & ~prev) : (~sync & prev). STATUS bit sets when event & IE and stays set until W1C.
  - Level pin: STATUS bit = IE & (sync == IPOL), re-evaluated every cycle. W1C has no effect.
- Clearing IE does not clear a sticky edge STATUS bit.
- Changing ITYPE from edge to level: the level rule applies from the next cycle.
- Edge event and W1C on the same bit in the same cycle: set wins, bit stays 1.
- DATA write and SET/CLR cannot coincide, since there is one transfer per cycle.

## Timing
Reset (HRESETn low):
- All registers, synchroniser flops and prev clear to 0 immediately, asynchronously. This gives GPIOOUT=0, GPIOEN=0, GPIOINT=0, GPIOIRQ=0, HRDATA=0, and HREADYOUT=1, HRESP=0 throughout.
- Reset mid-transfer aborts it. A pending write is lost.
- After release, the first valid address phase is accepted on the first HCLK edge.

Latencies:
- Pad change to DIN visible: SYNC_STAGES edges.
- Pad change to edge STATUS/GPIOIRQ set: SYNC_STAGES+1 edges.
- Pad change to level STATUS set: SYNC_STAGES edges.
- Register write to GPIOOUT/GPIOEN change: same edge that ends the write data phase.

Back-to-back transfers:
- A read whose address phase overlaps a preceding write's data phase returns the new value.
- A read of STATUS in the same data phase as an edge event returns the pre-event value.

## Test plan
- Reset: assert HRESETn low mid-write of DATA=0xFFFF -> GPIOOUT=0, GPIOEN=0, GPIOIRQ=0, all readbacks 0 after release.
- Output path: write DIR=0x00FF, DATA=0x0F0F, SET=0x1000, CLR=0x000F -> GPIOEN=0x00FF, GPIOOUT=0x1F00; back-to-back write-then-read of DATA returns 0x1F00 with zero wait states.
- Input sync: drive GPIOIN=0xA5A5 -> DIN reads 0 until SYNC_STAGES edges elapse, then 0xA5A5; a 0x1FC access reads 0 with HRESP=0.
- Rising edge IRQ, pin 3: set IE=0x0008, ITYPE=0x0008, IPOL=0x0008, pulse GPIOIN[3] high for one cycle.
  - GPIOIRQ rises SYNC_STAGES+1 edges later and stays high after the pin returns low.
  - W1C STATUS=0x0008 drops it.
  - A second edge coincident with the W1C leaves STATUS=0x0008.
- Level-low IRQ, pin 0: set IE=1, ITYPE=0, IPOL=0, GPIOIN[0]=0.
  - STATUS[0]=1, and a W1C does not clear it.
  - Driving GPIOIN[0]=1 clears it after SYNC_STAGES edges.
  - Clearing IE also clears it.
- Width corner, GPIO_WIDTH=5: write 0xFFFFFFFF to DATA, DIR and IE -> readbacks are 0x1F and upper output bits are absent.

Source files
------------

// File: rtl/ahb_gpio_irq.sv
// AHB-Lite GPIO slave: per-pin direction, atomic set/clear writes and
// edge/level interrupts with sticky W1C status; zero wait states.
module ahb_gpio_irq #(
    parameter int GPIO_WIDTH  = 16,
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 8
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [31:0]           HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [31:0]           HRDATA,
    input  logic [GPIO_WIDTH-1:0] GPIOIN,
    output logic [GPIO_WIDTH-1:0] GPIOOUT,
    output logic [GPIO_WIDTH-1:0] GPIOEN,
    output logic [GPIO_WIDTH-1:0] GPIOINT,
    output logic                  GPIOIRQ
);
    localparam int AW = ADDR_W - 2;
    localparam int W  = GPIO_WIDTH;

    typedef logic [W-1:0] pins_t;

    logic          acc;
    logic          wr_q;
    logic          rd_q;
    logic [AW-1:0] idx_q;
    logic [31:0]   rdata;
    logic          unused_bits;

    pins_t data_q, dir_q, ie_q, itype_q, ipol_q;
    pins_t edge_q, prev_q, din, wd, w1c;
    pins_t ev, lvl, status;
    pins_t sync_q [SYNC_STAGES];

    logic hit_data, hit_dir, hit_din, hit_set, hit_clr;
    logic hit_ie, hit_itype, hit_ipol, hit_stat;

    assign acc         = HSEL & HREADY & HTRANS[1];
    assign unused_bits = ^{HSIZE, HADDR, HWDATA};

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            idx_q <= '0;
        end else begin
            wr_q <= acc & HWRITE;
            rd_q <= acc & ~HWRITE;
            if (acc) idx_q <= HADDR[ADDR_W-1:2];
        end
    end

    assign hit_data  = idx_q == AW'(0);
    assign hit_dir   = idx_q == AW'(1);
    assign hit_din   = idx_q == AW'(2);
    assign hit_set   = idx_q == AW'(3);
    assign hit_clr   = idx_q == AW'(4);
    assign hit_ie    = idx_q == AW'(5);
    assign hit_itype = idx_q == AW'(6);
    assign hit_ipol  = idx_q == AW'(7);
    assign hit_stat  = idx_q == AW'(8);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            prev_q <= '0;
        end else begin
            sync_q[0] <= GPIOIN;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev_q <= din;
        end
    end

    assign din = sync_q[SYNC_STAGES-1];
    assign wd  = HWDATA[W-1:0];
    assign w1c = (wr_q & hit_stat) ? wd : '0;
    assign ev  = (ipol_q & din & ~prev_q) | (~ipol_q & ~din & prev_q);
    assign lvl = ie_q & ~(din ^ ipol_q);

    // A new edge event beats a simultaneous W1C on the same bit.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            data_q  <= '0;
            dir_q   <= '0;
            ie_q    <= '0;
            itype_q <= '0;
            ipol_q  <= '0;
            edge_q  <= '0;
        end else begin
            if (wr_q) begin
                unique case (1'b1)
                    hit_data:  data_q  <= wd;
                    hit_set:   data_q  <= data_q | wd;
                    hit_clr:   data_q  <= data_q & ~wd;
                    hit_dir:   dir_q   <= wd;
                    hit_ie:    ie_q    <= wd;
                    hit_itype: itype_q <= wd;
                    hit_ipol:  ipol_q  <= wd;
                    default: ;
                endcase
            end
            edge_q <= (edge_q & ~w1c) | (ev & ie_q & itype_q);
        end
    end

    assign status = (itype_q & edge_q) | (~itype_q & lvl);

    always_comb begin
        rdata = '0;
        if (rd_q) begin
            unique case (1'b1)
                hit_data:  rdata[W-1:0] = data_q;
                hit_dir:   rdata[W-1:0] = dir_q;
                hit_din:   rdata[W-1:0] = din;
                hit_ie:    rdata[W-1:0] = ie_q;
                hit_itype: rdata[W-1:0] = itype_q;
                hit_ipol:  rdata[W-1:0] = ipol_q;
                hit_stat:  rdata[W-1:0] = status;
                default: ;
            endcase
        end
    end

    assign HRDATA    = rdata;
    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;
    assign GPIOOUT   = data_q;
    assign GPIOEN    = dir_q;
    assign GPIOINT   = status;
    assign GPIOIRQ   = |status;

endmodule

// File: tb/tb_ahb_gpio_irq.sv
// Scoreboard bench for ahb_gpio_irq: directed and random AHB traffic with
// pad activity, checked against a behavioural register/interrupt model.
module tb_ahb_gpio_irq;
    localparam int W  = 16;
    localparam int S  = 2;
    localparam int NW = 5;

    logic          HCLK;
    logic          HRESETn;
    logic          HSEL;
    logic          HWRITE;
    logic          HREADY;
    logic [31:0]   HADDR;
    logic [31:0]   HWDATA;
    logic [1:0]    HTRANS;
    logic [2:0]    HSIZE;
    logic          HREADYOUT, HRESP, GPIOIRQ;
    logic [31:0]   HRDATA;
    logic [W-1:0]  GPIOIN, GPIOOUT, GPIOEN, GPIOINT;
    logic          n_readyout, n_resp, n_irq;
    logic [31:0]   n_rdata;
    logic [NW-1:0] n_out, n_en, n_int;

    ahb_gpio_irq #(.GPIO_WIDTH(W), .SYNC_STAGES(S), .ADDR_W(8)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
        .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
        .HRDATA(HRDATA), .GPIOIN(GPIOIN), .GPIOOUT(GPIOOUT),
        .GPIOEN(GPIOEN), .GPIOINT(GPIOINT), .GPIOIRQ(GPIOIRQ)
    );

    ahb_gpio_irq #(.GPIO_WIDTH(NW), .SYNC_STAGES(S), .ADDR_W(8)) dut_n (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
        .HREADY(HREADY), .HREADYOUT(n_readyout), .HRESP(n_resp),
        .HRDATA(n_rdata), .GPIOIN(GPIOIN[NW-1:0]), .GPIOOUT(n_out),
        .GPIOEN(n_en), .GPIOINT(n_int), .GPIOIRQ(n_irq)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [W-1:0] out;
        logic [W-1:0] en;
        logic [W-1:0] irqs;
        time          t;
    } pin_t;

    int n_chk = 0;
    int n_err = 0;

    // Reference state: register contents, sticky edge flags, pad history.
    logic [W-1:0] m_out, m_dir, m_ie, m_it, m_ip, m_stk, pad;
    logic [W-1:0] hist[$];
    bit           pend_w, pend_acc;
    logic [5:0]   pend_idx;
    logic [31:0]  pend_wd;
    logic [31:0]  rd_q[$];
    pin_t         pin_q[$];
    logic         dp_rd;
    pin_t         mon_p;
    logic [31:0]  mon_e;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] m_din();
        return hist[hist.size()-S];
    endfunction

    function automatic logic [W-1:0] m_status();
        logic [W-1:0] d;
        d = m_din();
        return (m_it & m_stk) | (~m_it & m_ie & ~(d ^ m_ip));
    endfunction

    function automatic logic [31:0] m_read(input logic [5:0] idx);
        logic [W-1:0] v;
        case (idx)
            6'd0: v = m_out;
            6'd1: v = m_dir;
            6'd2: v = m_din();
            6'd5: v = m_ie;
            6'd6: v = m_it;
            6'd7: v = m_ip;
            6'd8: v = m_status();
            default: v = '0;
        endcase
        return {16'h0, v};
    endfunction

    task automatic model_reset();
        m_out = '0; m_dir = '0; m_ie = '0;
        m_it = '0; m_ip = '0; m_stk = '0;
        hist.delete();
        for (int i = 0; i <= S; i++) hist.push_back('0);
        pend_w = 0; pend_acc = 0;
        rd_q.delete();
        pin_q.delete();
    endtask

    // One clock edge of the reference: pad edges, pending write, new pad sample.
    task automatic model_edge(input logic [31:0] dw);
        logic [W-1:0] d, p, ev, clr, v;
        d = hist[hist.size()-S];
        p = hist[hist.size()-S-1];
        v = dw[W-1:0];
        ev = (m_ip & d & ~p) | (~m_ip & ~d & p);
        clr = (pend_w && pend_idx == 6'd8) ? v : '0;
        m_stk = (m_stk & ~clr) | (ev & m_ie & m_it);
        if (pend_w) begin
            case (pend_idx)
                6'd0: m_out = v;
                6'd1: m_dir = v;
                6'd3: m_out = m_out | v;
                6'd4: m_out = m_out & ~v;
                6'd5: m_ie = v;
                6'd6: m_it = v;
                6'd7: m_ip = v;
                default: ;
            endcase
        end
        hist.push_back(pad);
        void'(hist.pop_front());
    endtask

    task automatic cycle(input bit v, input bit w, input logic [31:0] a,
                         input logic [31:0] wd, input bit stall = 0);
        logic [31:0] dw;
        bit acc;
        pin_t p;
        HSEL   = v ? 1'b1 : 1'($urandom_range(0, 1));
        HTRANS = {v, 1'($urandom_range(0, 1))};
        HREADY = !stall;
        HADDR  = v ? a : $urandom;
        HWRITE = v ? w : 1'($urandom_range(0, 1));
        HSIZE  = 3'($urandom_range(0, 2));
        dw     = pend_w ? pend_wd : $urandom;
        HWDATA = dw;
        GPIOIN = pad;
        acc = HSEL && HREADY && HTRANS[1];
        model_edge(dw);
        pend_acc = acc;
        pend_w   = acc && HWRITE;
        pend_idx = HADDR[7:2];
        pend_wd  = wd;
        if (acc && !HWRITE) rd_q.push_back(m_read(HADDR[7:2]));
        p.out  = m_out;
        p.en   = m_dir;
        p.irqs = m_status();
        p.t    = $time + 9;
        pin_q.push_back(p);
        @(posedge HCLK);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0);
    endtask

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) dp_rd <= 1'b0;
        else dp_rd <= HSEL & HREADY & HTRANS[1] & ~HWRITE;
    end

    always @(negedge HCLK) begin
        if (HRESETn) begin
            chk("hreadyout", {31'h0, HREADYOUT & n_readyout}, 32'h1);
            chk("hresp", {31'h0, HRESP | n_resp}, 32'h0);
            while (pin_q.size() > 0 && pin_q[0].t < $time) begin
                mon_p = pin_q.pop_front();
                chk("gpioout", {16'h0, GPIOOUT}, {16'h0, mon_p.out});
                chk("gpioen", {16'h0, GPIOEN}, {16'h0, mon_p.en});
                chk("gpioint", {16'h0, GPIOINT}, {16'h0, mon_p.irqs});
                chk("gpioirq", {31'h0, GPIOIRQ}, {31'h0, |mon_p.irqs});
                chk("n_gpioout", {27'h0, n_out}, {27'h0, mon_p.out[NW-1:0]});
                chk("n_gpioen", {27'h0, n_en}, {27'h0, mon_p.en[NW-1:0]});
                chk("n_gpioint", {27'h0, n_int}, {27'h0, mon_p.irqs[NW-1:0]});
                chk("n_gpioirq", {31'h0, n_irq}, {31'h0, |mon_p.irqs[NW-1:0]});
            end
            if (dp_rd) begin
                if (rd_q.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL rd_underflow: got read with no expected value at %0t", $time);
                end else begin
                    mon_e = rd_q.pop_front();
                    chk("hrdata", HRDATA, mon_e);
                    chk("n_hrdata", n_rdata, mon_e & 32'h1F);
                end
            end else begin
                chk("hrdata_idle", HRDATA | n_rdata, 32'h0);
            end
        end
    end

    task automatic mid_write_reset();
        cycle(1, 1, 32'h00, 32'h0000_FFFF);
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        HWDATA = 32'h0000_FFFF;
        #2 HRESETn = 1'b0;
        model_reset();
        #1;
        chk("rst_gpioout", {16'h0, GPIOOUT}, 32'h0);
        chk("rst_gpioen", {16'h0, GPIOEN}, 32'h0);
        chk("rst_gpioirq", {31'h0, GPIOIRQ}, 32'h0);
        chk("rst_hrdata", HRDATA, 32'h0);
        chk("rst_hreadyout", {31'h0, HREADYOUT}, 32'h1);
        chk("rst_hresp", {31'h0, HRESP}, 32'h0);
        repeat (2) @(posedge HCLK);
        #1 HRESETn = 1'b1;
    endtask

    initial begin
        logic [31:0] a, d;
        int op, idx;
        HRESETn = 1'b0;
        HSEL = 0; HWRITE = 0; HREADY = 1; HADDR = 0;
        HWDATA = 0; HTRANS = 0; HSIZE = 3'd2;
        pad = '0;
        GPIOIN = '0;
        model_reset();
        repeat (3) @(posedge HCLK);
        #1 HRESETn = 1'b1;

        for (int i = 0; i < 9; i++) cycle(1, 0, 32'(i * 4), 0);

        // Output path, then back-to-back write/read of DATA.
        cycle(1, 1, 32'h04, 32'h00FF);
        cycle(1, 1, 32'h00, 32'h0F0F);
        cycle(1, 1, 32'h0C, 32'h1000);
        cycle(1, 1, 32'h10, 32'h000F);
        cycle(1, 0, 32'h00, 0);
        chk("out_path_en", {16'h0, GPIOEN}, 32'h00FF);
        chk("out_path_out", {16'h0, GPIOOUT}, 32'h1F00);
        cycle(1, 0, 32'h0C, 0);
        cycle(1, 0, 32'h10, 0);

        // Input synchroniser and unmapped offset.
        pad = 16'hA5A5;
        for (int i = 0; i < 4; i++) cycle(1, 0, 32'h08, 0);
        cycle(1, 0, 32'h1FC, 0);
        chk("unmapped_hresp", {31'h0, HRESP}, 32'h0);
        pad = '0;
        idle(4);

        // Rising-edge interrupt on pin 3.
        cycle(1, 1, 32'h14, 32'h8);
        cycle(1, 1, 32'h18, 32'h8);
        cycle(1, 1, 32'h1C, 32'h8);
        idle(1);
        pad = 16'h0008;
        idle(1);
        pad = '0;
        idle(1);
        chk("rise_early", {31'h0, GPIOIRQ}, 32'h0);
        idle(1);
        chk("rise_irq", {31'h0, GPIOIRQ}, 32'h1);
        idle(3);
        chk("rise_sticky", {31'h0, GPIOIRQ}, 32'h1);
        cycle(1, 0, 32'h20, 0);
        cycle(1, 1, 32'h20, 32'h8);
        idle(1);
        chk("rise_w1c", {31'h0, GPIOIRQ}, 32'h0);
        pad = 16'h0008;
        idle(1);
        pad = '0;
        cycle(1, 1, 32'h20, 32'h8);
        cycle(1, 0, 32'h20, 0);
        chk("set_beats_w1c", {16'h0, GPIOINT}, 32'h8);
        cycle(1, 1, 32'h20, 32'h8);
        idle(1);

        // Level-low interrupt on pin 0.
        cycle(1, 1, 32'h18, 32'h0);
        cycle(1, 1, 32'h1C, 32'h0);
        cycle(1, 1, 32'h14, 32'h1);
        idle(1);
        chk("lvl_set", {16'h0, GPIOINT}, 32'h1);
        cycle(1, 1, 32'h20, 32'h1);
        idle(1);
        chk("lvl_no_w1c", {16'h0, GPIOINT}, 32'h1);
        pad = 16'h0001;
        idle(1);
        chk("lvl_hold", {16'h0, GPIOINT}, 32'h1);
        idle(1);
        chk("lvl_clear", {16'h0, GPIOINT}, 32'h0);
        pad = '0;
        idle(2);
        chk("lvl_again", {16'h0, GPIOINT}, 32'h1);
        cycle(1, 1, 32'h14, 32'h0);
        idle(1);
        chk("lvl_ie_off", {16'h0, GPIOINT}, 32'h0);
        cycle(1, 1, 32'h14, 32'h1);
        idle(1);
        chk("lvl_ie_on", {31'h0, GPIOIRQ}, 32'h1);

        mid_write_reset();
        for (int i = 0; i < 9; i++) cycle(1, 0, 32'(i * 4), 0);

        // Narrow-instance width corner.
        cycle(1, 1, 32'h00, 32'hFFFF_FFFF);
        cycle(1, 1, 32'h04, 32'hFFFF_FFFF);
        cycle(1, 1, 32'h14, 32'hFFFF_FFFF);
        cycle(1, 0, 32'h00, 0);
        cycle(1, 0, 32'h04, 0);
        cycle(1, 0, 32'h14, 0);
        chk("narrow_out", {27'h0, n_out}, 32'h1F);
        chk("narrow_en", {27'h0, n_en}, 32'h1F);
        chk("wide_out", {16'h0, GPIOOUT}, 32'hFFFF);
        idle(1);

        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 3) == 0) pad = pad ^ W'($urandom);
            op  = $urandom_range(0, 9);
            idx = $urandom_range(0, 12);
            a   = ($urandom & 32'hFFFF_FF03) | 32'(idx << 2);
            d   = $urandom;
            if (op <= 3) cycle(1, 1, a, d);
            else if (op <= 6) cycle(1, 0, a, 0);
            else if (op == 7) cycle(1, 0, $urandom, 0);
            else if (op == 8 && !pend_acc) cycle(1, 0, a, 0, 1);
            else idle(1);
        end
        idle(3);
        chk("rd_q_drained", 32'(rd_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
